paralelo_serial: RTL and testbench

- Serializer stage fed by the clock-generator output domain. It runs entirely on clk8f.
- It takes one WIDTH-bit parallel word every WIDTH cycles and shifts it out MSB first on a single serial line.
- Invalid slots and the post-reset sync preamble carry the COMMA idle symbol.
- It generates its own word-boundary strobe, so the upstream stage needs no extra clock.

---
 rtl/paralelo_serial.sv | 68 ++++++
 tb/tb_paralelo_serial.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/paralelo_serial.sv
// Parallel-to-serial stage on clk8f: one WIDTH-bit word every WIDTH cycles, MSB first,
// with a COMMA sync preamble after reset and a self-generated word-boundary strobe.
module paralelo_serial #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               IDLE_WORDS = 4
) (
  input  logic             clk8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             serial_out,
  output logic             word_tick,
  output logic             active
);

  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ICW = (IDLE_WORDS > 1) ? $clog2(IDLE_WORDS) : 1;

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [ICW-1:0]   r_idle_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_active;

  logic             w_load;
  logic [WIDTH-1:0] w_load_word;

  assign w_load = (r_bit_cnt == '0);

  // Preamble words ignore the input entirely; after sync, invalid slots become COMMA.
  always_comb begin
    w_load_word = COMMA;
    if (r_state == ST_ACTIVE && valid_in) w_load_word = data_in;
  end

  always_ff @(posedge clk8f) begin
    if (reset) begin
      r_state    <= ST_SYNC;
      r_bit_cnt  <= '0;
      r_idle_cnt <= '0;
      r_shreg    <= '0;
      r_active   <= 1'b0;
    end else begin
      r_bit_cnt <= (r_bit_cnt == CW'(WIDTH-1)) ? '0 : r_bit_cnt + 1'b1;

      if (w_load) r_shreg <= w_load_word;
      else        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};

      // The word loaded on the last preamble edge is still COMMA; data starts one word later.
      if (w_load && r_state == ST_SYNC) begin
        if (r_idle_cnt == ICW'(IDLE_WORDS-1)) begin
          r_state  <= ST_ACTIVE;
          r_active <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign serial_out = r_shreg[WIDTH-1];
  assign word_tick  = (r_state == ST_ACTIVE) && w_load;
  assign active     = r_active;

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: expected serial bits go into a queue when words are driven
// and are popped and compared one per cycle after each rising edge.
module tb_paralelo_serial;
  localparam int               WIDTH      = 8;
  localparam logic [WIDTH-1:0] COMMA      = 8'hBC;
  localparam int               IDLE_WORDS = 4;

  logic             clk8f = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic             serial_out, word_tick, active;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  paralelo_serial #(.WIDTH(WIDTH), .COMMA(COMMA), .IDLE_WORDS(IDLE_WORDS)) dut (
    .clk8f(clk8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .serial_out(serial_out), .word_tick(word_tick), .active(active)
  );

  always #5 clk8f = ~clk8f;

  // Bit scoreboard: one expected bit per cycle after each edge
  always @(posedge clk8f) begin
    logic e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (serial_out !== e) begin
        errors++;
        $display("FAIL serial_bit t=%0t got %b want %b", $time, serial_out, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH-1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // Wait (bounded) for the strobe at a falling edge, drive, and record expectation.
  task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ew);
    int n = 0;
    @(negedge clk8f);
    while (word_tick !== 1'b1 && n < 2*WIDTH) begin
      @(negedge clk8f);
      n++;
    end
    if (word_tick !== 1'b1) chk("word_tick_timeout", {31'd0, word_tick}, 32'd1);
    valid_in = v;
    data_in  = d;
    push_word(ew);
    @(posedge clk8f);
  endtask

  // Reset for 3 cycles, then check the preamble timing of active/word_tick.
  task automatic do_reset(input logic v, input logic [WIDTH-1:0] d);
    @(negedge clk8f);
    exp_q.delete();
    reset = 1'b1;
    repeat (3) @(posedge clk8f);
    #2;
    chk("rst_serial", {31'd0, serial_out}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_tick", {31'd0, word_tick}, 32'd0);
    @(negedge clk8f);
    valid_in = v;
    data_in  = d;
    reset    = 1'b0;
    for (int i = 0; i < IDLE_WORDS; i++) push_word(COMMA);
    repeat (IDLE_WORDS*WIDTH - WIDTH) @(posedge clk8f);
    #2;
    chk("sync_active_lo", {31'd0, active}, 32'd0);
    chk("sync_tick_lo", {31'd0, word_tick}, 32'd0);
    @(posedge clk8f);
    #2;
    chk("active_rise", {31'd0, active}, 32'd1);
    repeat (WIDTH-1) @(posedge clk8f);
    #2;
    chk("first_tick", {31'd0, word_tick}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 8'hA5, COMMA};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 8'h00};
    vecs[4] = '{1'b1, COMMA, COMMA};
    vecs[5] = '{1'b0, 8'h5A, COMMA};
    vecs[6] = '{1'b1, 8'h81, 8'h81};
    vecs[7] = '{1'b1, 8'h7E, 8'h7E};

    // Sync preamble with valid data offered; it must be ignored.
    do_reset(1'b1, 8'h55);

    foreach (vecs[i]) send(vecs[i].valid, vecs[i].data, vecs[i].exp_word);

    // Mid-word data change does not corrupt the word in flight.
    send(1'b1, 8'h3C, 8'h3C);
    repeat (2) @(negedge clk8f);
    data_in = 8'hC3;
    send(1'b0, 8'hC3, COMMA);
    send(1'b1, 8'hC3, 8'hC3);

    // Reset mid-word at bit_cnt==4 of an A5 word.
    send(1'b1, 8'hA5, 8'hA5);
    repeat (3) @(posedge clk8f);
    @(negedge clk8f);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk8f);
    #2;
    chk("midrst_serial", {31'd0, serial_out}, 32'd0);
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_tick", {31'd0, word_tick}, 32'd0);
    do_reset(1'b1, 8'hA5);
    send(1'b1, 8'h96, 8'h96);
    send(1'b0, 8'h00, COMMA);

    repeat (WIDTH + 2) @(posedge clk8f);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
